// File: rtl/column_scheduler_pkg.sv
// Shared types and defaults for the column scheduler.
// Holds the FSM state encoding and the angle/offset wrap-around helper.
package column_scheduler_pkg;

    localparam int DEF_NB_ANGLES = 128;
    localparam int DEF_COL_WIDTH = 48;
    localparam int DEF_OVR_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WAIT    = 2'd2,
        PRESENT = 2'd3
    } state_e;

    // Modulo-2^width add; callers truncate the result to their angle width.
    function automatic logic [31:0] angle_wrap_add(input logic [31:0] a,
                                                   input logic [31:0] b,
                                                   input int          width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return (a + b) & mask;
    endfunction

endpackage

// File: rtl/column_scheduler_edge_detect.sv
// Rising-edge detector: registers the input once and flags the 0->1 transition.
// A level held high for many cycles produces a single one-cycle rise.
module edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/column_scheduler.sv
// Column scheduler: fetches a RAM column on every angle change and presents it to the LED driver.
// Optional macro ANGLE_OFFSET_EN adds angle_offset_i, applied to the fetched/reported angle.
module column_scheduler
    import column_scheduler_pkg::*;
#(
    parameter int NB_ANGLES   = DEF_NB_ANGLES,
    parameter int ANGLE_WIDTH = $clog2(NB_ANGLES),
    parameter int COL_WIDTH   = DEF_COL_WIDTH,
    parameter int OVR_WIDTH   = DEF_OVR_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [ANGLE_WIDTH-1:0] angle_i,
`ifdef ANGLE_OFFSET_EN
    input  logic [ANGLE_WIDTH-1:0] angle_offset_i,
`endif
    input  logic                   turn_tick_i,
    output logic                   rd_en_o,
    output logic [ANGLE_WIDTH:0]   rd_addr_o,
    input  logic [COL_WIDTH-1:0]   rd_data_i,
    output logic                   col_valid_o,
    output logic [COL_WIDTH-1:0]   col_data_o,
    output logic [ANGLE_WIDTH-1:0] col_angle_o,
    input  logic                   col_ready_i,
    input  logic                   swap_req_i,
    output logic                   swap_ack_o,
    output logic                   disp_bank_o,
    output logic [OVR_WIDTH-1:0]   overrun_cnt_o
);

    state_e                 state_q;
    logic [ANGLE_WIDTH-1:0] prev_angle_q;
    logic                   pending_q;
    logic [ANGLE_WIDTH-1:0] pend_angle_q;
    logic                   rd_en_q;
    logic [ANGLE_WIDTH:0]   rd_addr_q;
    logic                   col_valid_q;
    logic [COL_WIDTH-1:0]   col_data_q;
    logic [ANGLE_WIDTH-1:0] col_angle_q;
    logic                   swap_ack_q;
    logic                   disp_bank_q;
    logic [OVR_WIDTH-1:0]   overrun_q;

    logic                   new_slot;
    logic                   tick_rise;
    logic                   swap_fire;
    logic                   bank_d;
    logic [ANGLE_WIDTH-1:0] cur_target_d;
    logic [ANGLE_WIDTH-1:0] sel_target_d;
    logic [OVR_WIDTH-1:0]   overrun_d;

    edge_detect u_tick_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sig_i  (turn_tick_i),
        .rise_o (tick_rise)
    );

    assign new_slot  = (angle_i != prev_angle_q);
    assign swap_fire = tick_rise & swap_req_i;
    // A swap in the same cycle as a fetch decision is visible to that fetch.
    assign bank_d    = disp_bank_q ^ swap_fire;
    assign overrun_d = (&overrun_q) ? overrun_q : overrun_q + 1'b1;

`ifdef ANGLE_OFFSET_EN
    assign cur_target_d = ANGLE_WIDTH'(angle_wrap_add(32'(angle_i), 32'(angle_offset_i), ANGLE_WIDTH));
`else
    assign cur_target_d = angle_i;
`endif

    assign sel_target_d = new_slot ? cur_target_d : pend_angle_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            prev_angle_q <= '0;
            pending_q    <= 1'b0;
            pend_angle_q <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            col_valid_q  <= 1'b0;
            col_data_q   <= '0;
            col_angle_q  <= '0;
            swap_ack_q   <= 1'b0;
            disp_bank_q  <= 1'b0;
            overrun_q    <= '0;
        end else begin
            prev_angle_q <= angle_i;
            swap_ack_q   <= swap_fire;
            disp_bank_q  <= bank_d;
            rd_en_q      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (new_slot || pending_q) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= {bank_d, sel_target_d};
                        pending_q <= 1'b0;
                        state_q   <= READ;
                    end
                end
                READ: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    col_data_q  <= rd_data_i;
                    col_angle_q <= rd_addr_q[ANGLE_WIDTH-1:0];
                    col_valid_q <= 1'b1;
                    state_q     <= PRESENT;
                end
                PRESENT: begin
                    if (col_ready_i) begin
                        col_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Busy: keep only the newest angle; replacing an unserved one is an overrun.
            if (new_slot && (state_q != IDLE)) begin
                pending_q    <= 1'b1;
                pend_angle_q <= cur_target_d;
                if (pending_q) begin
                    overrun_q <= overrun_d;
                end
            end
        end
    end

    assign rd_en_o       = rd_en_q;
    assign rd_addr_o     = rd_addr_q;
    assign col_valid_o   = col_valid_q;
    assign col_data_o    = col_data_q;
    assign col_angle_o   = col_angle_q;
    assign swap_ack_o    = swap_ack_q;
    assign disp_bank_o   = disp_bank_q;
    assign overrun_cnt_o = overrun_q;

endmodule

// File: doc/column_scheduler.md
Name: column_scheduler

Overview:
- Sequences column delivery for the rotating LED display.
- Watches the angle index from the angle computer. On every angle change it fetches that column from a double-banked column RAM and hands it to the LED driver over a valid/ready handshake.
- Host bank swaps are applied only at turn boundaries, signalled by a turn_tick rising edge, so a frame never tears mid-rotation.
- Slots the driver cannot take in time are counted as overruns.

Parameters:
- NB_ANGLES, 128, angles per turn; power of 2.
- ANGLE_WIDTH, $clog2(NB_ANGLES), angle index width.
- COL_WIDTH, 48, bits per column word.
- OVR_WIDTH, 16, overrun counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- angle  in  ANGLE_WIDTH  current angle from the angle computer.
- turn_tick  in  1  once-per-turn marker; may be high for many cycles.
- rd_en  out  1  column RAM read strobe.
- rd_addr  out  ANGLE_WIDTH+1  {bank, angle}.
- rd_data  in  COL_WIDTH  RAM data; valid exactly 1 cycle after rd_en.
- col_valid  out  1  column available to the driver.
- col_data  out  COL_WIDTH  column word.
- col_angle  out  ANGLE_WIDTH  angle of col_data.
- col_ready  in  1  driver accepts the column.
- swap_req  in  1  host requests a bank swap; level, held until ack.
- swap_ack  out  1  1-cycle pulse when the swap takes effect.
- disp_bank  out  1  bank currently displayed.
- overrun_cnt  out  OVR_WIDTH  saturating count of dropped slots.

Behaviour:
- Reset values: all outputs 0; state IDLE; prev_angle register = 0; pending = 0.
- Angle change detection: new_slot = (angle != prev_angle). prev_angle updates every cycle. There is no slot at reset until angle first differs from 0.
- Turn edge detection: tick_rise = turn_tick & ~turn_tick_d. Edge-detected so a long tick pulse swaps once.
- FSM IDLE: on new_slot or pending → READ. Target angle = current angle, or the pending angle if no new_slot. Clear pending.
- FSM READ: rd_en=1 and rd_addr={disp_bank, target} for 1 cycle → WAIT.
- FSM WAIT: capture rd_data into col_data, set col_angle = target → PRESENT. col_valid rises this next cycle.
- FSM PRESENT: col_valid=1; col_data and col_angle held stable. On col_valid&col_ready → IDLE, col_valid=0 next cycle.
- Best-case latency: angle change to col_valid = 3 cycles.
- Busy-slot rule: new_slot while not in IDLE → store angle as pending. If pending was already set, overwrite it and increment overrun_cnt (saturate at all-ones). Only the latest angle is kept.
- Stale-column rule: new_slot while in PRESENT with a pending slot already stored → the presented column is still delivered; the handshake is never withdrawn.
- Swap: tick_rise with swap_req=1 → disp_bank toggles next cycle, with a swap_ack pulse in the same cycle as the toggle.
  - An in-flight read uses the bank latched at READ.
  - swap_req without tick_rise → no effect.
- Simultaneous tick_rise and new_slot in IDLE: swap takes effect first; the read uses the new bank.
- Wrap-around: angle NB_ANGLES-1 → 0 is an ordinary new_slot.
- rst asserted mid-operation: state, col_valid, pending, disp_bank and overrun_cnt return to reset values on the next clk edge. A pending swap is not acked.

Optional Feature:
- Macro ANGLE_OFFSET_EN.
- Defined: adds input angle_offset [ANGLE_WIDTH]. The target angle = (angle + angle_offset) mod NB_ANGLES, taken from natural ANGLE_WIDTH overflow. The offset is used for rd_addr and col_angle. Change detection still uses the raw angle.
- Not defined: no port; target = angle.

Decomposition:
- Package column_scheduler_pkg holds:
  - the state enum typedef {IDLE, READ, WAIT, PRESENT};
  - default constants NB_ANGLES, COL_WIDTH, OVR_WIDTH;
  - a helper function for the angle/offset wrap add.
- One natural sub-module: edge_detect (1-bit rising-edge detector, registered). Instantiated for turn_tick.
- Angle change detection is inline.

Test Plan:
- Reset then angle 0→5, col_ready tied 1, RAM word at addr {0,5} = 48'hA5 → rd_en at cycle 1, col_valid at cycle 3 with col_data=48'hA5, col_angle=5.
- col_ready held 0; angle steps 5→6→7 → col stays angle 5. pending=7, overrun_cnt=1. After ready, next column is angle 7.
- swap_req=1 with turn_tick held high 50 cycles → exactly one swap_ack, disp_bank=1. The next read uses addr bit ANGLE_WIDTH = 1.
- Swap tick_rise coincident with an angle change from 127→0 → read addr = {1,0}, no overrun.
- rst pulsed 1 cycle while in PRESENT with overrun_cnt=3 → col_valid=0, overrun_cnt=0, disp_bank=0 next cycle.
- ANGLE_OFFSET_EN defined, angle_offset=120, angle 10 → rd_addr angle field = 2, col_angle = 2.
